// File: rtl/eth_pkg.sv
// Shared constants, state encoding and capture payload for the UDP command receiver.
package eth_pkg;

    localparam int unsigned OFF_W        = 16;
    localparam int unsigned BYTE_CNT_MAX = 2047;

    localparam int unsigned OFF_MAC      = 0;
    localparam int unsigned OFF_ETYPE    = 12;
    localparam int unsigned OFF_IPVER    = 14;
    localparam int unsigned OFF_PROTO    = 23;
    localparam int unsigned OFF_SRCIP    = 26;
    localparam int unsigned OFF_DSTIP    = 30;
    localparam int unsigned OFF_SRCPORT  = 34;
    localparam int unsigned OFF_DSTPORT  = 36;
    localparam int unsigned OFF_UDPLEN   = 38;
    localparam int unsigned OFF_PAYLOAD  = 42;
    localparam int unsigned CMD_PDU_LEN  = 8;

    localparam int unsigned OFF_CMD      = OFF_PAYLOAD;
    localparam int unsigned OFF_NCMD     = OFF_PAYLOAD + 2;
    localparam int unsigned OFF_PARAM    = OFF_PAYLOAD + 4;
    localparam int unsigned OFF_LAST     = OFF_PAYLOAD + CMD_PDU_LEN - 1;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_LEN_MIN    = 16'd16;
    localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;

    // One-hot receive states, same style as the TX session
    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_HDR     = 5'b00010,
        S_PAYLOAD = 5'b00100,
        S_WAIT    = 5'b01000,
        S_DROP    = 5'b10000
    } rx_state_e;

    // Fields shifted in from the wire while a frame streams past
    typedef struct packed {
        logic [31:0] src_ip;
        logic [15:0] src_port;
        logic [7:0]  udp_len_hi;
        logic [15:0] cmd;
        logic [15:0] ncmd;
        logic [31:0] param;
    } rx_cap_t;

    // True when off lies in [base, base+len)
    function automatic logic in_field(input logic [OFF_W-1:0] off,
                                      input int unsigned base,
                                      input int unsigned len);
        return (off >= OFF_W'(base)) && (off < OFF_W'(base + len));
    endfunction

endpackage

// File: rtl/counter16.sv
// 16-bit loadable up-counter that saturates at SAT.
module counter16 #(
    parameter logic [15:0] SAT = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Load has priority over increment; hold at SAT
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_rx_field_cmp.sv
// Byte-serial compare of a constant field at a fixed frame offset with a sticky match.
module eth_rx_field_cmp
    import eth_pkg::*;
#(
    parameter int unsigned           OFFSET = 0,
    parameter int unsigned           BYTES  = 1,
    parameter logic [8*BYTES-1:0]    VALUE  = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [7:0]       data_i,
    output logic             match_c_o
);

    logic       match_q;
    logic       match_d;
    logic       hit;
    logic [7:0] exp_byte;

    // Expected byte for this offset; the match re-arms on start of frame
    always_comb begin
        hit      = 1'b0;
        exp_byte = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (off_i == OFF_W'(OFFSET + i)) begin
                hit      = 1'b1;
                exp_byte = VALUE[8*(BYTES-1-i) +: 8];
            end
        end
        match_d = (start_i ? 1'b1 : match_q) & ~(valid_i & hit & (data_i != exp_byte));
    end

    // Sticky match register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match_c_o = match_d;

endmodule

// File: rtl/eth_cmd_rx.sv
// Ethernet/IPv4/UDP command receiver: filters frames, validates the command PDU, hands one command at a time to the controller.
module eth_cmd_rx
    import eth_pkg::*;
#(
    parameter logic [47:0]  LOCAL_MAC  = 48'h000A35010203,
    parameter logic [31:0]  LOCAL_IP   = 32'hC0A80102,
    parameter logic [15:0]  LOCAL_PORT = 16'd8080,
    parameter int unsigned  DROP_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_sof,
    input  logic              i_rx_eof,
    input  logic              i_rx_err,
    input  logic              i_cmd_finish,
    output logic [15:0]       o_cmd,
    output logic [31:0]       o_param,
    output logic              o_cmd_come,
    output logic              o_busy,
    output logic [31:0]       o_src_ip,
    output logic [15:0]       o_src_port,
    output logic [DROP_W-1:0] o_drop_cnt
);

    rx_state_e         st_q, st_d;
    rx_cap_t           cap_q, cap_d;
    logic              addr_q, addr_d;
    logic              err_q, err_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [31:0]       param_q, param_d;
    logic [31:0]       sip_q, sip_d;
    logic [15:0]       sport_q, sport_d;
    logic              come_q, come_d;
    logic              busy_q, busy_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic             start;
    logic             in_byte;
    logic [OFF_W-1:0] byte_cnt;
    logic [OFF_W-1:0] cur_off;
    logic             mac_c, bcast_c, etype_c, ip_c, port_c;
    logic             misc_bad;
    logic             hdr_ok;
    logic             err_seen;
    logic             busy_eff;
    logic             pdu_ok;
    logic             commit;
    logic             reject;

    assign start    = i_rx_valid & i_rx_sof;
    assign in_byte  = i_rx_valid & (i_rx_sof | (st_q != S_IDLE));
    assign cur_off  = i_rx_sof ? '0 : byte_cnt;
    assign err_seen = err_q | i_rx_err;
    assign busy_eff = busy_q & ~i_cmd_finish;

    // Holds the offset of the next expected byte
    counter16 #(.SAT(16'(BYTE_CNT_MAX))) u_byte_cnt (
        .clk_i      (i_clk),
        .rst_n_i    (i_rst_n),
        .load_i     (start),
        .load_val_i (16'd1),
        .inc_i      (in_byte & ~start),
        .cnt_o      (byte_cnt)
    );

    eth_rx_field_cmp #(.OFFSET(OFF_MAC), .BYTES(6), .VALUE(LOCAL_MAC)) u_mac (
        .clk_i(i_clk), .rst_n_i(i_rst_n), .start_i(start), .valid_i(in_byte),
        .off_i(cur_off), .data_i(i_rx_data), .match_c_o(mac_c)
    );

    eth_rx_field_cmp #(.OFFSET(OFF_MAC), .BYTES(6), .VALUE(MAC_BCAST)) u_bcast (
        .clk_i(i_clk), .rst_n_i(i_rst_n), .start_i(start), .valid_i(in_byte),
        .off_i(cur_off), .data_i(i_rx_data), .match_c_o(bcast_c)
    );

    eth_rx_field_cmp #(.OFFSET(OFF_ETYPE), .BYTES(2), .VALUE(ETHERTYPE_IPV4)) u_etype (
        .clk_i(i_clk), .rst_n_i(i_rst_n), .start_i(start), .valid_i(in_byte),
        .off_i(cur_off), .data_i(i_rx_data), .match_c_o(etype_c)
    );

    eth_rx_field_cmp #(.OFFSET(OFF_DSTIP), .BYTES(4), .VALUE(LOCAL_IP)) u_ip (
        .clk_i(i_clk), .rst_n_i(i_rst_n), .start_i(start), .valid_i(in_byte),
        .off_i(cur_off), .data_i(i_rx_data), .match_c_o(ip_c)
    );

    eth_rx_field_cmp #(.OFFSET(OFF_DSTPORT), .BYTES(2), .VALUE(LOCAL_PORT)) u_port (
        .clk_i(i_clk), .rst_n_i(i_rst_n), .start_i(start), .valid_i(in_byte),
        .off_i(cur_off), .data_i(i_rx_data), .match_c_o(port_c)
    );

    // Field capture, single-byte header checks and address-match tracking
    always_comb begin
        cap_d = cap_q;
        if (in_byte) begin
            if (in_field(cur_off, OFF_SRCIP, 4))   cap_d.src_ip     = {cap_q.src_ip[23:0], i_rx_data};
            if (in_field(cur_off, OFF_SRCPORT, 2)) cap_d.src_port   = {cap_q.src_port[7:0], i_rx_data};
            if (in_field(cur_off, OFF_UDPLEN, 1))  cap_d.udp_len_hi = i_rx_data;
            if (in_field(cur_off, OFF_CMD, 2))     cap_d.cmd        = {cap_q.cmd[7:0], i_rx_data};
            if (in_field(cur_off, OFF_NCMD, 2))    cap_d.ncmd       = {cap_q.ncmd[7:0], i_rx_data};
            if (in_field(cur_off, OFF_PARAM, 4))   cap_d.param      = {cap_q.param[23:0], i_rx_data};
        end

        misc_bad = in_byte &
                   (((cur_off == OFF_W'(OFF_IPVER)) && (i_rx_data != IP_VER_IHL)) ||
                    ((cur_off == OFF_W'(OFF_PROTO)) && (i_rx_data != IP_PROTO_UDP)) ||
                    ((cur_off == OFF_W'(OFF_UDPLEN + 1)) &&
                     ({cap_q.udp_len_hi, i_rx_data} < UDP_LEN_MIN)));
        hdr_ok = (mac_c | bcast_c) & etype_c & ip_c & port_c & ~misc_bad;

        addr_d = addr_q;
        if (start) begin
            addr_d = 1'b0;
        end else if (in_byte && (st_q == S_HDR) && (cur_off == OFF_W'(OFF_DSTPORT + 1)) &&
                     (mac_c | bcast_c) && ip_c && port_c) begin
            addr_d = 1'b1;
        end

        if (start) begin
            err_d = i_rx_err;
        end else if (st_q != S_IDLE) begin
            err_d = err_q | i_rx_err;
        end else begin
            err_d = 1'b0;
        end

        pdu_ok = (cap_d.ncmd == ~cap_d.cmd) & ~err_seen & ~busy_eff;
    end

    // Frame FSM: decides commit or counted reject at frame boundaries
    always_comb begin
        st_d   = st_q;
        commit = 1'b0;
        reject = 1'b0;
        if (start) begin
            reject = (st_q != S_IDLE) & addr_q;
            st_d   = i_rx_eof ? S_IDLE : S_HDR;
        end else if (i_rx_valid) begin
            case (st_q)
                S_IDLE: st_d = S_IDLE;
                S_HDR: begin
                    if (i_rx_eof) begin
                        st_d   = S_IDLE;
                        reject = addr_d;
                    end else if (!hdr_ok) begin
                        st_d = S_DROP;
                    end else if (cur_off == OFF_W'(OFF_PAYLOAD - 1)) begin
                        st_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (i_rx_eof) begin
                        st_d = S_IDLE;
                        if ((cur_off == OFF_W'(OFF_LAST)) && pdu_ok) commit = 1'b1;
                        else                                          reject = 1'b1;
                    end else if (cur_off == OFF_W'(OFF_LAST)) begin
                        st_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_rx_eof) begin
                        st_d = S_IDLE;
                        if (pdu_ok) commit = 1'b1;
                        else        reject = 1'b1;
                    end
                end
                S_DROP: begin
                    if (i_rx_eof) begin
                        st_d   = S_IDLE;
                        reject = addr_q;
                    end
                end
                default: st_d = S_IDLE;
            endcase
        end
    end

    // Output next-state: command latch, handshake flags, saturating drop count
    always_comb begin
        cmd_d   = cmd_q;
        param_d = param_q;
        sip_d   = sip_q;
        sport_d = sport_q;
        if (commit) begin
            cmd_d   = cap_d.cmd;
            param_d = cap_d.param;
            sip_d   = cap_d.src_ip;
            sport_d = cap_d.src_port;
        end
        come_d = commit;
        busy_d = commit | busy_eff;
        drop_d = drop_q;
        if (reject && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            st_q    <= S_IDLE;
            cap_q   <= '0;
            addr_q  <= 1'b0;
            err_q   <= 1'b0;
            cmd_q   <= '0;
            param_q <= '0;
            sip_q   <= '0;
            sport_q <= '0;
            come_q  <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            st_q    <= st_d;
            cap_q   <= cap_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            param_q <= param_d;
            sip_q   <= sip_d;
            sport_q <= sport_d;
            come_q  <= come_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign o_cmd      = cmd_q;
    assign o_param    = param_q;
    assign o_src_ip   = sip_q;
    assign o_src_port = sport_q;
    assign o_cmd_come = come_q;
    assign o_busy     = busy_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_eth_cmd_rx.sv
// Randomized self-checking bench for eth_cmd_rx against a frame-level reference model.
module tb_eth_cmd_rx;

    localparam logic [47:0] L_MAC  = 48'h000A35010203;
    localparam logic [31:0] L_IP   = 32'hC0A80102;
    localparam logic [15:0] L_PORT = 16'd8080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_sof = 1'b0;
    logic        rx_eof = 1'b0;
    logic        rx_err = 1'b0;
    logic        cmd_finish = 1'b0;
    logic [15:0] o_cmd;
    logic [31:0] o_param;
    logic        o_cmd_come;
    logic        o_busy;
    logic [31:0] o_src_ip;
    logic [15:0] o_src_port;
    logic [15:0] o_drop_cnt;

    always #5 clk = ~clk;

    eth_cmd_rx dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .i_rx_sof     (rx_sof),
        .i_rx_eof     (rx_eof),
        .i_rx_err     (rx_err),
        .i_cmd_finish (cmd_finish),
        .o_cmd        (o_cmd),
        .o_param      (o_param),
        .o_cmd_come   (o_cmd_come),
        .o_busy       (o_busy),
        .o_src_ip     (o_src_ip),
        .o_src_port   (o_src_port),
        .o_drop_cnt   (o_drop_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [15:0] m_cmd = '0, m_sport = '0, m_drop = '0;
    logic [31:0] m_param = '0, m_sip = '0;
    bit          m_busy = 1'b0;
    int          pend = 0;
    logic [7:0]  fq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; cmd_finish = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic push_be(input logic [63:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) fq.push_back(8'(v >> (8 * i)));
    endtask

    task automatic build(input logic [47:0] mac, input logic [31:0] dip, input logic [15:0] dport,
                         input logic [31:0] sip, input logic [15:0] sport, input logic [15:0] cmd,
                         input logic [15:0] ncmd, input logic [31:0] param, input int extra,
                         input logic [15:0] ulen);
        fq.delete();
        push_be(64'(mac), 6);
        push_be(64'h001122334455, 6);
        push_be(64'h0800, 2);
        push_be(64'h45, 1);
        push_be(64'h00, 1);
        push_be(64'(16'd36 + 16'(extra)), 2);
        push_be(64'h1234, 2);
        push_be(64'h4000, 2);
        push_be(64'h40, 1);
        push_be(64'h11, 1);
        push_be(64'hBEEF, 2);
        push_be(64'(sip), 4);
        push_be(64'(dip), 4);
        push_be(64'(sport), 2);
        push_be(64'(dport), 2);
        push_be(64'(ulen), 2);
        push_be(64'h0000, 2);
        push_be(64'(cmd), 2);
        push_be(64'(ncmd), 2);
        push_be(64'(param), 4);
        for (int i = 0; i < extra; i++) fq.push_back(8'($urandom));
    endtask

    task automatic good(input logic [31:0] sip, input logic [15:0] sport,
                        input logic [15:0] cmd, input logic [31:0] param);
        build(L_MAC, L_IP, L_PORT, sip, sport, cmd, ~cmd, param, 0, 16'd16);
    endtask

    // 0 = ignored, 1 = counted reject, 2 = commit; n bytes of fq were sent
    function automatic int ref_outcome(input int n, input bit err, input bit beff, input bit ended);
        logic [47:0] mac;
        bit hdr_ok;
        if (n < 38) return 0;
        mac = {fq[0], fq[1], fq[2], fq[3], fq[4], fq[5]};
        hdr_ok = ((mac == L_MAC) || (mac == 48'hFFFFFFFFFFFF)) &&
                 ({fq[12], fq[13]} == 16'h0800) && (fq[14] == 8'h45) && (fq[23] == 8'h11) &&
                 ({fq[30], fq[31], fq[32], fq[33]} == L_IP) && ({fq[36], fq[37]} == L_PORT);
        if (!hdr_ok) return 0;
        if (!ended || n < 50) return 1;
        if ({fq[38], fq[39]} < 16'd16) return 1;
        if ({fq[44], fq[45]} != ~{fq[42], fq[43]}) return 1;
        if (err || beff) return 1;
        return 2;
    endfunction

    task automatic bump_drop();
        if (m_drop != 16'hFFFF) m_drop++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_cmd"},   64'(o_cmd),      64'(m_cmd));
        chk({tag, "_param"}, 64'(o_param),    64'(m_param));
        chk({tag, "_sip"},   64'(o_src_ip),   64'(m_sip));
        chk({tag, "_sport"}, 64'(o_src_port), 64'(m_sport));
        chk({tag, "_busy"},  64'(o_busy),     64'(m_busy));
        chk({tag, "_drop"},  64'(o_drop_cnt), 64'(m_drop));
    endtask

    // Stream the first n bytes of fq; ended=0 leaves the frame open for a sof abort or reset
    task automatic send(input string tag, input int n, input int err_at, input bit fin, input bit ended);
        int oc;
        bit err;
        err = (err_at >= 0) && (err_at < n);
        if (pend == 1) bump_drop();
        pend = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk); idle_inputs();
            end
            @(negedge clk);
            rx_valid   = 1'b1;
            rx_data    = fq[i];
            rx_sof     = (i == 0);
            rx_eof     = ended && (i == n - 1);
            rx_err     = (i == err_at);
            cmd_finish = fin && ended && (i == n - 1);
        end
        oc = ref_outcome(n, err, m_busy && !fin, ended);
        if (!ended) begin
            pend = oc;
        end else begin
            if (oc == 1) bump_drop();
            if (oc == 2) begin
                m_cmd   = {fq[42], fq[43]};
                m_param = {fq[46], fq[47], fq[48], fq[49]};
                m_sip   = {fq[26], fq[27], fq[28], fq[29]};
                m_sport = {fq[34], fq[35]};
                m_busy  = 1'b1;
            end else if (fin) begin
                m_busy = 1'b0;
            end
            @(negedge clk); idle_inputs();
            chk({tag, "_come"}, 64'(o_cmd_come), 64'(oc == 2));
            check_all(tag);
            @(negedge clk);
            chk({tag, "_come_1cyc"}, 64'(o_cmd_come), 64'd0);
        end
    endtask

    task automatic pulse_finish();
        @(negedge clk); idle_inputs(); cmd_finish = 1'b1;
        @(negedge clk); cmd_finish = 1'b0;
        m_busy = 1'b0;
        chk("finish_busy", 64'(o_busy), 64'd0);
    endtask

    task automatic stray_bytes();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle_inputs(); rx_valid = 1'b1;
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk); idle_inputs(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m_cmd = '0; m_param = '0; m_sip = '0; m_sport = '0; m_busy = 1'b0; m_drop = '0; pend = 0;
        chk("rst_come", 64'(o_cmd_come), 64'd0);
        check_all("rst");
    endtask

    initial begin
        logic [15:0] c, nc, dp;
        logic [31:0] dip;
        logic [47:0] mac;
        int n, err_at, extra, idx;
        bit fin, ended, last_ended;

        do_reset();

        // Nominal command from the test plan
        build(L_MAC, L_IP, L_PORT, 32'hC0A80164, 16'd5000, 16'h0021, 16'hFFDE, 32'h000001F4, 0, 16'd16);
        send("valid", fq.size(), -1, 0, 1);
        build(L_MAC, L_IP, L_PORT, 32'hC0A80164, 16'd5000, 16'h0021, 16'hFFDF, 32'h000001F4, 0, 16'd16);
        send("ncmd_bad", fq.size(), -1, 0, 1);
        good(32'hC0A80165, 16'd5001, 16'h0030, 32'h11223344);
        send("busy_rej", fq.size(), -1, 0, 1);
        good(32'hC0A80166, 16'd5002, 16'h0031, 32'h55667788);
        send("fin_eof", fq.size(), -1, 1, 1);
        build(L_MAC, L_IP, 16'd8081, 32'hC0A80167, 16'd5003, 16'h0040, 16'hFFBF, 32'h1, 0, 16'd16);
        send("port_bad", fq.size(), -1, 0, 1);
        build(L_MAC, 32'hC0A80103, L_PORT, 32'hC0A80167, 16'd5003, 16'h0040, 16'hFFBF, 32'h1, 0, 16'd16);
        send("ip_bad", fq.size(), -1, 0, 1);
        pulse_finish();
        build(48'hFFFFFFFFFFFF, L_IP, L_PORT, 32'h0A000001, 16'd6000, 16'h0050, 16'hFFAF, 32'hCAFEF00D, 3, 16'd19);
        send("bcast", fq.size(), -1, 0, 1);
        pulse_finish();
        good(32'h0A000002, 16'd6001, 16'h0060, 32'h0BADBEEF);
        send("err_pay", fq.size(), 45, 0, 1);
        good(32'h0A000003, 16'd6002, 16'h0070, 32'h01020304);
        send("abort", 21, -1, 0, 0);
        good(32'h0A000004, 16'd6003, 16'h0071, 32'h05060708);
        send("after_abort", fq.size(), -1, 0, 1);

        // Randomized frames
        last_ended = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (last_ended && m_busy && ($urandom_range(0, 2) == 0)) pulse_finish();
            if (last_ended && ($urandom_range(0, 5) == 0)) stray_bytes();
            case ($urandom_range(0, 9))
                0:       mac = {16'h0A0B, 32'($urandom)};
                1:       mac = 48'hFFFFFFFFFFFF;
                default: mac = L_MAC;
            endcase
            dip   = ($urandom_range(0, 7) == 0) ? (L_IP ^ 32'h1) : L_IP;
            dp    = ($urandom_range(0, 7) == 0) ? (L_PORT ^ 16'h1) : L_PORT;
            c     = 16'($urandom);
            nc    = ($urandom_range(0, 5) == 0) ? (c ^ 16'h0100) : ~c;
            extra = $urandom_range(0, 4);
            build(mac, dip, dp, $urandom, 16'($urandom), c, nc, $urandom, extra,
                  ($urandom_range(0, 9) == 0) ? 16'd15 : 16'(16 + extra));
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0: idx = 12;
                    1: idx = 13;
                    2: idx = 14;
                    default: idx = 23;
                endcase
                fq[idx] = fq[idx] ^ 8'h01;
            end
            n      = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 49) : fq.size();
            err_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            fin    = ($urandom_range(0, 4) == 0);
            ended  = ($urandom_range(0, 9) != 0);
            send("rnd", n, err_at, fin, ended);
            last_ended = ended;
        end
        if (!last_ended) begin
            good(32'h0A000005, 16'd6004, 16'h0072, 32'h0);
            send("rnd_tail", fq.size(), -1, 0, 1);
        end

        // Reset in the middle of a payload, then a clean frame
        pulse_finish();
        good(32'h0A000006, 16'd6005, 16'h0080, 32'hAAAA5555);
        send("pre_rst", 46, -1, 0, 0);
        do_reset();
        good(32'h0A000007, 16'd6006, 16'h0081, 32'h12345678);
        send("post_rst", fq.size(), -1, 0, 1);

        // Drop counter saturation
        @(negedge clk); force dut.drop_q = 16'hFFFE;
        @(negedge clk); release dut.drop_q;
        m_drop = 16'hFFFE;
        chk("drop_preset", 64'(o_drop_cnt), 64'(m_drop));
        build(L_MAC, L_IP, L_PORT, 32'h0A000008, 16'd6007, 16'h0090, 16'h0090, 32'h0, 0, 16'd16);
        send("sat1", fq.size(), -1, 0, 1);
        send("sat2", fq.size(), -1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
